// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and defaults for the multi-cycle SRAM data-memory stage.
package arm_mem_pkg;

  // Access sequencer: one idle/accept state, one state per half-word, one hand-off cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [31:0] BASE_ADDR_DEF   = 32'd1024;
  localparam int          SRAM_AW_DEF     = 18;
  localparam int          SRAM_DW         = 16;
  localparam int          WAIT_CYCLES_DEF = 5;

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// Pipeline-side request/response plus SRAM pin bundle for the memory stage.
interface sram_mem_ctrl_if #(
  parameter int SRAM_AW = 18
);
  import arm_mem_pkg::*;

  logic               rd_en;
  logic               wr_en;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [SRAM_DW-1:0] sram_dq_out;
  logic               sram_dq_oe;
  logic [SRAM_DW-1:0] sram_dq_in;
  logic               sram_we_n;

  // Controller side.
  modport slave (
    input  rd_en, wr_en, addr, wdata, sram_dq_in,
    output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  // Pipeline/SRAM side (pipeline drives requests, SRAM drives read data).
  modport master (
    output rd_en, wr_en, addr, wdata, sram_dq_in,
    input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

endinterface

// File: rtl/sram_mem_ctrl.sv
// Multi-cycle MEM stage: each 32-bit load/store becomes two 16-bit SRAM
// accesses (low half then high half), each WAIT_CYCLES long. ready drops
// while an access is in flight so the top level can freeze the pipeline.
module sram_mem_ctrl
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter int          SRAM_AW     = SRAM_AW_DEF,
  parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF   // must be >= 2
) (
  input  logic           clk,
  input  logic           rst,
  sram_mem_ctrl_if.slave bus
);

  localparam int CW = $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(WAIT_CYCLES - 2);

  state_e             state;
  logic [CW-1:0]      cnt;
  logic               op_wr;
  logic [SRAM_AW-2:0] idx;
  logic [31:0]        wdata_q;
  logic [SRAM_AW-2:0] idx_in;
  logic               req;
  logic               last;

  // Word index into SRAM: offset from the base, byte lane bits dropped, wraps modulo.
  assign idx_in = (SRAM_AW-1)'((bus.addr - BASE_ADDR) >> 2);
  assign req    = bus.rd_en | bus.wr_en;
  assign last   = (cnt == CNT_LAST);

  // Stage may advance only when idle with nothing asked, or on the hand-off cycle.
  assign bus.ready = ((state == S_IDLE) && !req) || (state == S_DONE);

  // Sequencer with registered SRAM pins; pin values are set one edge ahead
  // so they are stable for the whole cycle they apply to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      op_wr           <= 1'b0;
      idx             <= '0;
      wdata_q         <= '0;
      bus.rdata       <= '0;
      bus.sram_addr   <= '0;
      bus.sram_dq_out <= '0;
      bus.sram_dq_oe  <= 1'b0;
      bus.sram_we_n   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            // Write wins when both enables are raised.
            state           <= S_LOW;
            cnt             <= '0;
            op_wr           <= bus.wr_en;
            idx             <= idx_in;
            wdata_q         <= bus.wdata;
            bus.sram_addr   <= {idx_in, 1'b0};
            bus.sram_dq_out <= bus.wdata[15:0];
            bus.sram_dq_oe  <= bus.wr_en;
            bus.sram_we_n   <= ~bus.wr_en;
          end
        end
        S_LOW: begin
          if (last) begin
            state           <= S_HIGH;
            cnt             <= '0;
            if (!op_wr) bus.rdata[15:0] <= bus.sram_dq_in;
            bus.sram_addr   <= {idx, 1'b1};
            bus.sram_dq_out <= wdata_q[31:16];
            bus.sram_we_n   <= ~op_wr;
          end else begin
            cnt <= cnt + 1'b1;
            // Strobe rises one cycle before the phase ends so data holds past it.
            if (cnt == CNT_PRE) bus.sram_we_n <= 1'b1;
          end
        end
        S_HIGH: begin
          if (last) begin
            state          <= S_DONE;
            cnt            <= '0;
            if (!op_wr) bus.rdata[31:16] <= bus.sram_dq_in;
            bus.sram_dq_oe <= 1'b0;
            bus.sram_we_n  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_PRE) bus.sram_we_n <= 1'b1;
          end
        end
        S_DONE: begin
          // Never re-accept here; a held request is taken in the next IDLE cycle.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: directed scenarios plus randomized loads/stores
// checked against a word-level memory model and a behavioural SRAM.
module tb_sram_mem_ctrl;
  import arm_mem_pkg::*;

  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sram_mem_ctrl_if #(.SRAM_AW(AW)) bus ();

  sram_mem_ctrl #(.BASE_ADDR(32'd1024), .SRAM_AW(AW), .WAIT_CYCLES(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural async SRAM: commits on the strobe's rising edge while data is still driven.
  logic [15:0] mem [0:(1<<AW)-1];
  logic        we_prev = 1'b1;
  assign bus.sram_dq_in = mem[bus.sram_addr];

  always @(negedge clk) begin
    if (!we_prev && bus.sram_we_n && bus.sram_dq_oe)
      mem[bus.sram_addr] <= bus.sram_dq_out;
    we_prev <= bus.sram_we_n;
  end

  // Word-level reference: 32-bit words indexed by (addr-1024)/4 modulo 2^17.
  logic [31:0] ref_mem [int unsigned];

  function automatic int unsigned widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return (off >> 2) & 32'h1FFFF;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(widx(a))) return ref_mem[widx(a)];
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access, started just after a posedge in an IDLE cycle; returns at the
  // negedge of the ready cycle. Counts freeze length and strobe activity per half.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rv, output int n, output int we_lo,
                        output int we_hi, output int oe_cnt);
    bit done;
    done   = 0;
    n      = 0;
    we_lo  = 0;
    we_hi  = 0;
    oe_cnt = 0;
    rv     = 'x;
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.addr  = a;
    bus.wdata = d;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.ready) begin
        done = 1;
        rv   = bus.rdata;
        break;
      end
      n++;
      if (!bus.sram_we_n && !bus.sram_addr[0]) we_lo++;
      if (!bus.sram_we_n &&  bus.sram_addr[0]) we_hi++;
      if (bus.sram_dq_oe) oe_cnt++;
    end
    if (!done) chk("timeout_ready", 32'd0, 32'd1);
  endtask

  // Access plus its checks against the reference; hold keeps the enables up through DONE.
  task automatic do_op(input string tag, input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] d, input bit hold);
    logic [31:0] rv;
    int n, we_lo, we_hi, oe_cnt, hw;
    access(wr, rd, a, d, rv, n, we_lo, we_hi, oe_cnt);
    chk({tag, "_freeze"}, n, 32'd11);
    if (wr) begin
      ref_mem[widx(a)] = d;
      hw = int'(widx(a)) * 2;
      chk({tag, "_we_lo"}, we_lo, 32'd4);
      chk({tag, "_we_hi"}, we_hi, 32'd4);
      chk({tag, "_oe"}, oe_cnt, 32'd10);
      chk({tag, "_sram_lo"}, {16'h0, mem[hw]}, {16'h0, d[15:0]});
      chk({tag, "_sram_hi"}, {16'h0, mem[hw+1]}, {16'h0, d[31:16]});
    end else begin
      chk({tag, "_we"}, we_lo + we_hi, 32'd0);
      chk({tag, "_oe"}, oe_cnt, 32'd0);
      chk({tag, "_rdata"}, rv, ref_rd(a));
    end
    if (!hold) begin
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a, d;
    bit wr, rd;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;

    // Reset held two clocks.
    repeat (2) next_cycle();
    chk("rst_ready", {31'h0, bus.ready}, 32'd1);
    chk("rst_we_n", {31'h0, bus.sram_we_n}, 32'd1);
    chk("rst_oe", {31'h0, bus.sram_dq_oe}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_addr", 32'(bus.sram_addr), 32'd0);
    rst = 1'b1;
    next_cycle();

    // Store, then load it back.
    do_op("t2_wr", 1, 0, 32'd1024, 32'hDEADBEEF, 0);
    next_cycle();
    do_op("t3_rd", 0, 1, 32'd1024, 32'h0, 0);
    next_cycle();

    // Byte lane bits ignored; neighbouring word untouched.
    do_op("t4_wr", 1, 0, 32'd1030, 32'h12345678, 0);
    chk("t4_sram2", {16'h0, mem[2]}, 32'h5678);
    next_cycle();
    do_op("t4_rd0", 0, 1, 32'd1024, 32'h0, 0);
    next_cycle();
    do_op("t4_rd1", 0, 1, 32'd1028, 32'h0, 0);
    next_cycle();

    // Reset during the second HIGH cycle of a store: low half lands, high half aborted.
    bus.wr_en = 1'b1;
    bus.addr  = 32'd1024;
    bus.wdata = 32'hCAFEF00D;
    repeat (7) next_cycle();
    rst = 1'b0;
    bus.wr_en = 1'b0;
    next_cycle();
    rst = 1'b1;
    chk("t5_ready", {31'h0, bus.ready}, 32'd1);
    chk("t5_we_n", {31'h0, bus.sram_we_n}, 32'd1);
    chk("t5_oe", {31'h0, bus.sram_dq_oe}, 32'd0);
    chk("t5_rdata", bus.rdata, 32'd0);
    @(negedge clk);
    chk("t5_sram0", {16'h0, mem[0]}, 32'hF00D);
    chk("t5_sram1", {16'h0, mem[1]}, 32'hDEAD);
    ref_mem[0] = 32'hDEADF00D;
    next_cycle();
    do_op("t5_rd", 0, 1, 32'd1024, 32'h0, 0);
    next_cycle();

    // Load held through DONE, store presented in the very next IDLE cycle.
    do_op("t6_rd", 0, 1, 32'd1028, 32'h0, 1);
    next_cycle();
    chk("t6_nogap_ready", {31'h0, bus.ready}, 32'd0);
    do_op("t6_wr", 1, 0, 32'd1032, 32'hA5A55A5A, 0);
    next_cycle();

    // Address below the base wraps to the top of the SRAM.
    do_op("wrap_wr", 1, 0, 32'd1020, 32'h0BADC0DE, 0);
    next_cycle();
    do_op("wrap_rd", 0, 1, 32'd1024 + 32'h1FFFF * 4, 32'h0, 0);
    next_cycle();

    // Randomized loads/stores over a small window; both enables means store.
    for (int i = 0; i < 24; i++) begin
      a  = 32'd1024 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      d  = $urandom;
      wr = ($urandom_range(0, 2) == 0);
      rd = !wr || ($urandom_range(0, 1) == 0);
      do_op(wr ? "rnd_wr" : "rnd_rd", wr, rd, a, d, 0);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
